seq_chk: RTL and testbench

- Consumer and checker for the 4-bit phase bus driven by seq_gen in s_proc_v1.
- Samples seq_gen's state and its ce, and locks onto the one-hot ring.
- Decodes the current phase into a binary index and per-phase strobes for the control path.
- Counts completed instruction cycles and flags illegal codes, illegal transitions and stall timeouts with a sticky error.

---
 rtl/seq_chk.sv | 179 +++++++++++++++++
 tb/tb_seq_chk.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chk.sv
// Checker for the 4-bit one-hot phase ring of seq_gen: locks onto the ring, decodes
// the phase, counts completed instruction cycles and latches the first error seen.
module seq_chk #(
    parameter int CNT_W     = 8,
    parameter int STALL_MAX = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ce,
    input  logic [3:0]       state,
    input  logic             err_clr,
    output logic             locked,
    output logic [1:0]       phase,
    output logic [3:0]       phase_stb,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int STALL_W = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_LOCK   = 2'd1,
        ST_ERR    = 2'd2
    } fsm_t;

    fsm_t               fsm_r;
    logic [3:0]         prev_state_r;
    logic               prev_ce_r;
    logic [STALL_W-1:0] stall_r;

    logic [3:0]         expected_s;
    logic               one_hot_s;
    logic [STALL_W-1:0] stall_next_s;
    logic               stall_hit_s;
    logic               wrap_s;
    logic [1:0]         chk_code_s;

    function automatic logic [3:0] rotl4(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    function automatic logic is_one_hot(input logic [3:0] v);
        logic any_s;
        logic multi_s;
        any_s   = 1'b0;
        multi_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                multi_s = multi_s | any_s;
                any_s   = 1'b1;
            end else begin
                multi_s = multi_s;
            end
        end
        return any_s & ~multi_s;
    endfunction

    function automatic logic [1:0] enc4(input logic [3:0] v);
        logic [1:0] idx_s;
        case (v)
            4'b0001: idx_s = 2'd0;
            4'b0010: idx_s = 2'd1;
            4'b0100: idx_s = 2'd2;
            4'b1000: idx_s = 2'd3;
            default: idx_s = 2'd0;
        endcase
        return idx_s;
    endfunction

    // Next-edge checks on the sampled bus: expected phase, saturating stall count, error code.
    always_comb begin
        expected_s   = prev_ce_r ? rotl4(prev_state_r) : prev_state_r;
        one_hot_s    = is_one_hot(state);
        stall_next_s = '0;
        stall_hit_s  = 1'b0;
        wrap_s       = 1'b0;
        chk_code_s   = 2'b00;
        if (ce) begin
            stall_next_s = '0;
        end else if (stall_r == STALL_LIM) begin
            stall_next_s = stall_r;
        end else begin
            stall_next_s = stall_r + STALL_W'(1'b1);
        end
        if ((STALL_MAX != 0) && !ce && (stall_next_s == STALL_LIM)) begin
            stall_hit_s = 1'b1;
        end else begin
            stall_hit_s = 1'b0;
        end
        if ((prev_state_r == 4'b1000) && prev_ce_r && (state == 4'b0001)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
        if (!one_hot_s) begin
            chk_code_s = 2'b01;
        end else if (state != expected_s) begin
            chk_code_s = 2'b10;
        end else if (stall_hit_s) begin
            chk_code_s = 2'b11;
        end else begin
            chk_code_s = 2'b00;
        end
    end

    // Lock/check/error state machine with all outputs registered.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            fsm_r        <= ST_UNLOCK;
            prev_state_r <= 4'b0000;
            prev_ce_r    <= 1'b0;
            stall_r      <= '0;
            locked       <= 1'b0;
            phase        <= 2'd0;
            phase_stb    <= 4'b0000;
            cycle_cnt    <= '0;
            err          <= 1'b0;
            err_code     <= 2'b00;
        end else begin
            prev_state_r <= state;
            prev_ce_r    <= ce;
            case (fsm_r)
                ST_UNLOCK: begin
                    if (state == 4'b0001) begin
                        fsm_r     <= ST_LOCK;
                        locked    <= 1'b1;
                        phase     <= 2'd0;
                        phase_stb <= 4'b0001;
                        cycle_cnt <= '0;
                        stall_r   <= '0;
                    end else begin
                        locked    <= 1'b0;
                        phase_stb <= 4'b0000;
                    end
                end
                ST_LOCK: begin
                    if (chk_code_s != 2'b00) begin
                        fsm_r     <= ST_ERR;
                        err       <= 1'b1;
                        err_code  <= chk_code_s;
                        locked    <= 1'b0;
                        phase_stb <= 4'b0000;
                    end else begin
                        phase     <= enc4(state);
                        phase_stb <= state;
                        stall_r   <= stall_next_s;
                        if (wrap_s) begin
                            cycle_cnt <= cycle_cnt + CNT_W'(1'b1);
                        end else begin
                            cycle_cnt <= cycle_cnt;
                        end
                    end
                end
                ST_ERR: begin
                    // err_clr beats any error that would be seen on the same edge.
                    if (err_clr) begin
                        fsm_r     <= ST_UNLOCK;
                        err       <= 1'b0;
                        err_code  <= 2'b00;
                        cycle_cnt <= '0;
                    end else begin
                        err       <= 1'b1;
                    end
                end
                default: begin
                    fsm_r     <= ST_UNLOCK;
                    locked    <= 1'b0;
                    phase_stb <= 4'b0000;
                    err       <= 1'b0;
                    err_code  <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chk.sv
// Scoreboard bench for seq_chk: emulates seq_gen, injects faults, and compares two
// instances (stall check on / off) against a rule-level reference model.
module tb_seq_chk;

    typedef struct packed {
        logic       locked;
        logic [1:0] phase;
        logic [3:0] stb;
        logic [7:0] cnt;
        logic       err;
        logic [1:0] code;
    } obs_t;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       ce = 1'b0;
    logic [3:0] state = 4'b0001;
    logic       err_clr = 1'b0;

    logic       locked_a, locked_b, err_a, err_b;
    logic [1:0] phase_a, phase_b, code_a, code_b;
    logic [3:0] stb_a, stb_b;
    logic [7:0] cnt_a, cnt_b;

    int tests = 0;
    int fails = 0;

    obs_t q0[$];
    obs_t q1[$];

    // reference model state, index 0: STALL_MAX=16, index 1: STALL_MAX=0
    int   sm[2] = '{16, 0};
    bit   m_lock[2];
    bit   m_err[2];
    int   m_code[2];
    int   m_phase[2];
    int   m_cnt[2];
    int   m_stall[2];
    int   m_stb[2];
    int   p_st = 0;
    bit   p_ce = 1'b0;
    int   gen = 1;

    seq_chk #(.CNT_W(8), .STALL_MAX(16)) dut (
        .clk(clk), .clr(clr), .ce(ce), .state(state), .err_clr(err_clr),
        .locked(locked_a), .phase(phase_a), .phase_stb(stb_a),
        .cycle_cnt(cnt_a), .err(err_a), .err_code(code_a)
    );

    seq_chk #(.CNT_W(8), .STALL_MAX(0)) dut0 (
        .clk(clk), .clr(clr), .ce(ce), .state(state), .err_clr(err_clr),
        .locked(locked_b), .phase(phase_b), .phase_stb(stb_b),
        .cycle_cnt(cnt_b), .err(err_b), .err_code(code_b)
    );

    always #5 clk = ~clk;

    function automatic obs_t act(input int i);
        obs_t o;
        if (i == 0) o = {locked_a, phase_a, stb_a, cnt_a, err_a, code_a};
        else        o = {locked_b, phase_b, stb_b, cnt_b, err_b, code_b};
        return o;
    endfunction

    function automatic obs_t model_obs(input int i);
        obs_t o;
        o.locked = m_lock[i];
        o.phase  = 2'(m_phase[i]);
        o.stb    = 4'(m_stb[i]);
        o.cnt    = 8'(m_cnt[i]);
        o.err    = m_err[i];
        o.code   = 2'(m_code[i]);
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got lk=%0b ph=%0d stb=%b cnt=%0d err=%0b code=%b, want lk=%0b ph=%0d stb=%b cnt=%0d err=%0b code=%b",
                     name, got.locked, got.phase, got.stb, got.cnt, got.err, got.code,
                     want.locked, want.phase, want.stb, want.cnt, want.err, want.code);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lock[i] = 1'b0; m_err[i] = 1'b0; m_code[i] = 0; m_phase[i] = 0;
            m_cnt[i] = 0; m_stall[i] = 0; m_stb[i] = 0;
        end
        p_st = 0;
        p_ce = 1'b0;
        gen  = 1;
    endtask

    // One sampling edge of the checker, written from the behavioural rules.
    task automatic model_step(input int i, input int st, input bit c, input bit ec);
        int expv, code, ns;
        if (m_err[i]) begin
            if (ec) begin
                m_err[i] = 1'b0; m_code[i] = 0; m_cnt[i] = 0;
            end
        end else if (!m_lock[i]) begin
            if (st == 1) begin
                m_lock[i] = 1'b1; m_cnt[i] = 0; m_stall[i] = 0; m_phase[i] = 0; m_stb[i] = 1;
            end
        end else begin
            expv = p_ce ? (((p_st << 1) | (p_st >> 3)) & 15) : p_st;
            ns   = c ? 0 : ((m_stall[i] + 1 > sm[i]) ? sm[i] : m_stall[i] + 1);
            code = 0;
            if ($countones(4'(st)) != 1)               code = 1;
            else if (st != expv)                       code = 2;
            else if (sm[i] != 0 && !c && ns == sm[i])  code = 3;
            if (code != 0) begin
                m_err[i] = 1'b1; m_code[i] = code; m_lock[i] = 1'b0; m_stb[i] = 0;
            end else begin
                m_phase[i] = $clog2(st);
                m_stb[i]   = st;
                if (p_st == 8 && p_ce && st == 1) m_cnt[i] = (m_cnt[i] + 1) % 256;
                m_stall[i] = ns;
            end
        end
    endtask

    // Drive one cycle; inj < 0 means the emulated seq_gen drives the bus.
    task automatic cycle(input bit c, input int inj, input bit ec);
        int st;
        @(negedge clk);
        clr     = 1'b1;
        st      = (inj < 0) ? gen : inj;
        ce      = c;
        state   = 4'(st);
        err_clr = ec;
        for (int i = 0; i < 2; i++) model_step(i, st, c, ec);
        p_st = st;
        p_ce = c;
        q0.push_back(model_obs(0));
        q1.push_back(model_obs(1));
        if (c) gen = ((gen << 1) | (gen >> 3)) & 15;
    endtask

    task automatic clr_pulse();
        obs_t zero;
        zero = '0;
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("async_reset_a", act(0), zero);
        check("async_reset_b", act(1), zero);
        model_reset();
        q0.push_back(model_obs(0));
        q1.push_back(model_obs(1));
    endtask

    // Monitor: compare the DUT after every edge for which an expectation was queued.
    always begin
        obs_t w;
        @(posedge clk);
        #2;
        if (q0.size() > 0) begin
            w = q0.pop_front();
            check("sb_stall16", act(0), w);
        end
        if (q1.size() > 0) begin
            w = q1.pop_front();
            check("sb_stall0", act(1), w);
        end
    end

    initial begin
        obs_t zero;
        int r;
        zero = '0;
        model_reset();
        @(negedge clk);
        #1;
        check("reset_a", act(0), zero);
        check("reset_b", act(1), zero);

        repeat (13) cycle(1'b1, -1, 1'b0);
        for (int k = 0; k < 8 && gen != 4; k++) cycle(1'b1, -1, 1'b0);
        repeat (5) cycle(1'b0, -1, 1'b0);
        repeat (3) cycle(1'b1, -1, 1'b0);

        repeat (100) cycle(1'b0, -1, 1'b0);
        cycle(1'b1, -1, 1'b1);
        repeat (8) cycle(1'b1, -1, 1'b0);

        for (int k = 0; k < 8 && gen != 1; k++) cycle(1'b1, -1, 1'b0);
        cycle(1'b1, -1, 1'b0);
        cycle(1'b1, 4, 1'b0);
        repeat (3) cycle(1'b1, -1, 1'b0);
        cycle(1'b1, -1, 1'b1);
        repeat (6) cycle(1'b1, -1, 1'b0);

        cycle(1'b1, 3, 1'b0);
        cycle(1'b1, -1, 1'b0);
        cycle(1'b1, 3, 1'b1);
        repeat (6) cycle(1'b1, -1, 1'b0);

        clr_pulse();
        repeat (6) cycle(1'b1, -1, 1'b0);

        repeat (1040) cycle(1'b1, -1, 1'b0);

        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2)       cycle(1'b1, int'($urandom_range(0, 15)), 1'b0);
            else if (r < 6)  cycle(1'b1, -1, 1'b1);
            else if (r < 25) cycle(1'b0, -1, 1'b0);
            else if (r < 26) clr_pulse();
            else             cycle(1'b1, -1, 1'b0);
        end

        @(posedge clk);
        #3;
        tests++;
        if (q0.size() + q1.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d pending, want 0", q0.size() + q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
